glitch_sequencer: RTL
=====================

// Module: glitch_sequencer
// PURPOSE
//  Arms on a command from the command block, waits for a qualified trigger edge on i_trig, then emits
//  a train of glitch pulses with programmable delay, width, gap and repeat count. Runs on the
//  100 MHz system clock. o_glitch feeds the output-mux gating in top. The status outputs drive the
//  arm, waiting and firing RGB LED PWM enables.
// PARAMETERS
//  CNT_W        32  width of delay/width/gap counters (cycles of clk)
//  REP_W        8   width of repeat count
//  SYNC_STAGES  2   flops in i_trig synchroniser (>=2)
// PORTS
//  clk           in   1      system clock (100 MHz)
//  reset_n       in   1      asynchronous, active-low reset
//  i_arm         in   1      1-cycle pulse: latch config, enter ARMED (ignored unless IDLE/DONE)
//  i_abort       in   1      level/pulse: return to IDLE from any state
//  i_trig_fall   in   1      0 = rising-edge trigger, 1 = falling-edge (sampled at arm)
//  i_delay       in   CNT_W  cycles from trigger detect to first pulse
//  i_width       in   CNT_W  pulse high time in cycles (0 treated as 1)
//  i_gap         in   CNT_W  low time between pulses (0 treated as 1)
//  i_repeat      in   REP_W  number of pulses (0 treated as 1)
//  i_trig        in   1      asynchronous external trigger
//  o_glitch      out  1      registered glitch pulse
//  o_armed       out  1      high in ARMED (waiting for trigger)
//  o_waiting     out  1      high in DELAY or GAP
//  o_firing      out  1      high in PULSE (equals o_glitch)
//  o_done        out  1      1-cycle pulse when the train completes normally
//  o_busy        out  1      high in any state except IDLE/DONE
//  o_pulse_cnt   out  REP_W  pulses emitted since last arm (saturating)
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0; config registers 0; synchroniser and edge-history flops cleared
//   to the inactive level (0 for rising, 1 for falling handled by the history flop loaded at arm).
//  Config latch: on i_arm in IDLE/DONE, latch delay, width, gap, repeat and trig_fall. Load the
//   edge-history flop with the current synchronised trig level so a level already high is not an
//   edge. Clear o_pulse_cnt. Go to ARMED next cycle.
//  Zero clamps: width, gap and repeat of 0 are latched as 1. Delay 0 is legal.
//  Edge detect: trig_s = last sync stage. Rising edge = trig_s & ~hist; falling edge = ~trig_s & hist.
//   hist <= trig_s every cycle.
//  FSM:
//   IDLE  -> ARMED on i_arm.
//   ARMED -> DELAY (cnt <= delay-1) on edge if delay > 0; else -> PULSE (cnt <= width-1).
//   DELAY -> PULSE when cnt == 0 (cnt <= width-1); else cnt--.
//   PULSE -> if pulses remaining > 1: GAP (cnt <= gap-1); else DONE. cnt-- otherwise.
//   GAP   -> PULSE when cnt == 0; else cnt--.
//   DONE  -> holds; o_done asserted only on the entry cycle; accepts i_arm like IDLE.
//  Pulse count: o_pulse_cnt increments on each PULSE entry and saturates at all-ones.
//  Latency: i_trig first sampled high at clock edge k (rising mode) gives o_glitch high after edge
//   k+SYNC_STAGES+delay. It stays high exactly width cycles and is low exactly gap cycles between
//   pulses.
//  Trigger edges outside ARMED are ignored (no retrigger, no queueing).
//  i_abort has priority over every transition, including a simultaneous i_arm or edge. Next edge:
//   IDLE, o_glitch 0, no o_done. o_pulse_cnt retains its value.
//  i_arm while busy is ignored. Config inputs may change freely after the arm cycle.
//  Counters are CNT_W wide, unsigned, and never wrap: loads are value-1 of a value >= 1. A delay of
//   2^CNT_W-1 is legal.
//  Mid-operation async reset forces o_glitch low immediately (asynchronous clear).
// TESTING
//  1. arm delay=10 width=5 gap=3 repeat=1; rise i_trig at edge k -> o_glitch high edges k+12..k+16
//     (5 cycles), o_done pulse one cycle after it falls, o_pulse_cnt=1.
//  2. delay=0 width=0 repeat=3 gap=2 -> three 1-cycle pulses spaced by 2 low cycles, first at
//     k+2; o_waiting high during gaps.
//  3. i_trig already high at arm, rising mode -> no fire. Drop then raise i_trig -> fires. Falling
//     mode: fires on the 1->0 transition only.
//  4. Assert i_abort during 2nd pulse of repeat=4 -> o_glitch low next edge, IDLE, no o_done,
//     o_pulse_cnt=2. Abort and i_arm in the same cycle -> stays IDLE.
//  5. Extra i_trig edges during DELAY/PULSE and i_arm while busy -> train timing unchanged.
//     Re-arm from DONE works.
//  6. reset_n low mid-PULSE (asynchronous, off clock edge) -> o_glitch/o_busy 0 immediately.
//     After release, IDLE and no pulse on a later trigger until armed.

Source files
------------

// File: rtl/glitch_sequencer.sv
// Glitch sequencer: arms on command, waits for a qualified trigger edge on an
// asynchronous input, then emits a train of pulses with programmable delay,
// width, gap and repeat count.
module glitch_sequencer #(
    parameter int unsigned CNT_W       = 32,
    parameter int unsigned REP_W       = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_arm,
    input  logic             i_abort,
    input  logic             i_trig_fall,
    input  logic [CNT_W-1:0] i_delay,
    input  logic [CNT_W-1:0] i_width,
    input  logic [CNT_W-1:0] i_gap,
    input  logic [REP_W-1:0] i_repeat,
    input  logic             i_trig,
    output logic             o_glitch,
    output logic             o_armed,
    output logic             o_waiting,
    output logic             o_firing,
    output logic             o_done,
    output logic             o_busy,
    output logic [REP_W-1:0] o_pulse_cnt
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ARMED = 3'd1,
        S_DELAY = 3'd2,
        S_PULSE = 3'd3,
        S_GAP   = 3'd4,
        S_DONE  = 3'd5
    } state_e;

    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [REP_W-1:0]       rem_q, rem_d;
    logic [CNT_W-1:0]       delay_q, delay_d;
    logic [CNT_W-1:0]       width_q, width_d;
    logic [CNT_W-1:0]       gap_q, gap_d;
    logic                   fall_q, fall_d;
    logic [REP_W-1:0]       pcnt_q, pcnt_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;
    logic                   glitch_q, armed_q, waiting_q, done_q, busy_q;

    logic trig_s_c;
    logic edge_c;

    assign trig_s_c = sync_q[SYNC_STAGES-1];
    // Polarity is fixed at arm time; history tracks the previous synchronised level.
    assign edge_c   = fall_q ? (~trig_s_c & hist_q) : (trig_s_c & ~hist_q);

    // Trigger synchroniser and edge-history flop.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
            hist_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], i_trig};
            hist_q <= trig_s_c;
        end
    end

    // State, counters and latched configuration.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            delay_q <= '0;
            width_q <= '0;
            gap_q   <= '0;
            fall_q  <= 1'b0;
            pcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            delay_q <= delay_d;
            width_q <= width_d;
            gap_q   <= gap_d;
            fall_q  <= fall_d;
            pcnt_q  <= pcnt_d;
        end
    end

    // Next-state logic; abort overrides every transition including arm.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        delay_d = delay_q;
        width_d = width_q;
        gap_d   = gap_q;
        fall_d  = fall_q;
        pcnt_d  = pcnt_q;

        if (i_abort) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (i_arm) begin
                        state_d = S_ARMED;
                        delay_d = i_delay;
                        width_d = (i_width  == '0) ? CNT_W'(1) : i_width;
                        gap_d   = (i_gap    == '0) ? CNT_W'(1) : i_gap;
                        rem_d   = (i_repeat == '0) ? REP_W'(1) : i_repeat;
                        fall_d  = i_trig_fall;
                        pcnt_d  = '0;
                    end
                end
                S_ARMED: begin
                    if (edge_c) begin
                        if (delay_q != '0) begin
                            state_d = S_DELAY;
                            cnt_d   = delay_q - CNT_W'(1);
                        end else begin
                            state_d = S_PULSE;
                            cnt_d   = width_q - CNT_W'(1);
                        end
                    end
                end
                S_DELAY, S_GAP: begin
                    if (cnt_q == '0) begin
                        state_d = S_PULSE;
                        cnt_d   = width_q - CNT_W'(1);
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                S_PULSE: begin
                    if (cnt_q == '0) begin
                        if (rem_q > REP_W'(1)) begin
                            state_d = S_GAP;
                            cnt_d   = gap_q - CNT_W'(1);
                            rem_d   = rem_q - REP_W'(1);
                        end else begin
                            state_d = S_DONE;
                        end
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        // Count each pulse start, saturating at all-ones.
        if ((state_d == S_PULSE) && (state_q != S_PULSE) && (pcnt_q != '1)) begin
            pcnt_d = pcnt_q + REP_W'(1);
        end
    end

    // Registered status outputs decoded from the next state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            glitch_q  <= 1'b0;
            armed_q   <= 1'b0;
            waiting_q <= 1'b0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            glitch_q  <= (state_d == S_PULSE);
            armed_q   <= (state_d == S_ARMED);
            waiting_q <= (state_d == S_DELAY) || (state_d == S_GAP);
            done_q    <= (state_d == S_DONE) && (state_q != S_DONE);
            busy_q    <= (state_d != S_IDLE) && (state_d != S_DONE);
        end
    end

    assign o_glitch    = glitch_q;
    assign o_firing    = glitch_q;
    assign o_armed     = armed_q;
    assign o_waiting   = waiting_q;
    assign o_done      = done_q;
    assign o_busy      = busy_q;
    assign o_pulse_cnt = pcnt_q;

endmodule
